// File: rtl/neuron_accum_if.sv
// Handshake bundle for neuron_accum: Q16.16 term stream in, IEEE-754 single result out.
interface neuron_accum_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [31:0] weight;
  logic [31:0] act;
  logic [31:0] bias;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] x_float;
  logic        sat;
  logic        len_err;

  modport master (
    output in_valid, in_last, weight, act, bias, out_ready,
    input  in_ready, out_valid, x_float, sat, len_err
  );

  modport slave (
    input  in_valid, in_last, weight, act, bias, out_ready,
    output in_ready, out_valid, x_float, sat, len_err
  );
endinterface

// File: rtl/neuron_accum.sv
// neuron_accum: Q16.16 multiply-accumulate onto a bias, saturate to 32 bits, convert to float.
// Optional macro NEURON_ACCUM_ROUND_EN rounds each term half-up instead of truncating toward -inf.
module neuron_accum #(
  parameter int N_INPUTS = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  neuron_accum_if.slave bus
);
  localparam int CW = $clog2(N_INPUTS + 1);
  localparam logic signed [47:0] SAT_MAX = 48'sh0000_7FFF_FFFF;
  localparam logic signed [47:0] SAT_MIN = 48'shFFFF_8000_0000;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCUM   = 2'd1,
    S_CONVERT = 2'd2,
    S_OUT     = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic signed [47:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic               r_len_pend;
  logic               r_out_valid;
  logic [31:0]        r_x_float;
  logic               r_sat;
  logic               r_len_err;

  logic signed [47:0] w_prod;
  logic signed [47:0] w_prod_adj;
  logic signed [31:0] w_term;
  logic signed [47:0] w_acc_base;
  logic signed [47:0] w_acc_nxt;
  logic [CW-1:0]      w_cnt_nxt;
  logic               w_in_ready;
  logic               w_accept;
  logic               w_xfer;
  logic               w_at_limit;
  logic               w_end;
  logic [31:0]        w_sat_val;
  logic               w_clip;

  // Exponent is biased by 127 and corrected by 16 for the Q16.16 binary point.
  function automatic logic [31:0] fix_to_float(input logic [31:0] s);
    logic [31:0] mag;
    logic [31:0] norm;
    logic [4:0]  p;
    begin
      mag  = s[31] ? (32'd0 - s) : s;
      p    = 5'd0;
      for (int i = 0; i < 32; i++) begin
        p = mag[i] ? 5'(i) : p;
      end
      norm = mag << (5'd31 - p);
      fix_to_float = (s == 32'd0) ? 32'd0
                   : {s[31], 8'd111 + {3'd0, p}, 23'(norm >> 8)};
    end
  endfunction

  always_comb begin
    w_prod = 48'(signed'(bus.weight)) * 48'(signed'(bus.act));
`ifdef NEURON_ACCUM_ROUND_EN
    w_prod_adj = w_prod + 48'sd32768;
`else
    w_prod_adj = w_prod;
`endif
    w_term     = 32'(w_prod_adj >>> 16);
    w_in_ready = (r_state == S_IDLE) || (r_state == S_ACCUM);
    w_accept   = bus.in_valid & w_in_ready;
    w_xfer     = r_out_valid & bus.out_ready;
    w_acc_base = (r_state == S_IDLE) ? {{16{bus.bias[31]}}, bus.bias} : r_acc;
    w_acc_nxt  = w_acc_base + {{16{w_term[31]}}, w_term};
    w_cnt_nxt  = (r_state == S_IDLE) ? CW'(1) : (r_cnt + CW'(1));
    w_at_limit = (w_cnt_nxt == CW'(N_INPUTS));
    w_end      = bus.in_last | w_at_limit;
  end

  always_comb begin
    if (r_acc > SAT_MAX) begin
      w_sat_val = 32'h7FFF_FFFF;
      w_clip    = 1'b1;
    end else if (r_acc < SAT_MIN) begin
      w_sat_val = 32'h8000_0000;
      w_clip    = 1'b1;
    end else begin
      w_sat_val = r_acc[31:0];
      w_clip    = 1'b0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_ACCUM: begin
        if (w_accept) begin
          w_state_nxt = w_end ? S_CONVERT : S_ACCUM;
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_CONVERT: w_state_nxt = S_OUT;
      S_OUT:     w_state_nxt = w_xfer ? S_IDLE : S_OUT;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // out_valid trails entry into S_OUT by one edge so the result is two edges behind the last term.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_acc       <= 48'sd0;
      r_cnt       <= CW'(0);
      r_len_pend  <= 1'b0;
      r_out_valid <= 1'b0;
      r_x_float   <= 32'd0;
      r_sat       <= 1'b0;
      r_len_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= (r_state == S_OUT) & ~w_xfer;
      if (w_accept) begin
        r_acc      <= w_acc_nxt;
        r_cnt      <= w_cnt_nxt;
        r_len_pend <= w_at_limit & ~bus.in_last;
      end
      if (r_state == S_CONVERT) begin
        r_x_float <= fix_to_float(w_sat_val);
        r_sat     <= w_clip;
        r_len_err <= r_len_pend;
      end else if (w_xfer) begin
        r_x_float <= 32'd0;
        r_sat     <= 1'b0;
        r_len_err <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.x_float   = r_x_float;
  assign bus.sat       = r_sat;
  assign bus.len_err   = r_len_err;
endmodule

// File: tb/tb_neuron_accum.sv
// Randomised and directed bench for neuron_accum against a real-arithmetic reference model.
module tb_neuron_accum;
  localparam int N_IN = 4;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic Clk = 1'b0;
  logic Reset;
  neuron_accum_if bus ();
  neuron_accum #(.N_INPUTS(N_IN)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  always #5 Clk = ~Clk;

  typedef struct { logic [31:0] x; logic sat; logic len; } res_t;

  int     n_checks = 0;
  int     n_fail   = 0;
  res_t   exp_q[$];
  bit     exp_busy  = 1'b0;
  bit     exp_valid = 1'b0;
  int     cd        = 0;
  int     m_cnt     = 0;
  longint m_acc     = 0;
  bit     last_acc  = 1'b0;
  bit     lit_armed = 1'b0;
  res_t   lit_res;
  string  lit_name;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, want, $time);
    end
  endtask

  function automatic longint model_term(input logic [31:0] w, input logic [31:0] a);
    longint p;
    p = longint'(int'(w)) * longint'(int'(a));
`ifdef NEURON_ACCUM_ROUND_EN
    p = p + 64'sd32768;
`endif
    return longint'(int'(p >>> 16));
  endfunction

  // Value as a double (exact for 32-bit ints), then its mantissa truncated to single width.
  function automatic res_t model_result(input longint acc, input bit len);
    res_t r;
    longint s;
    real v;
    logic [63:0] b;
    r.len = len;
    r.sat = 1'b0;
    s = acc;
    if (acc > MAXV) begin s = MAXV; r.sat = 1'b1; end
    else if (acc < MINV) begin s = MINV; r.sat = 1'b1; end
    if (s == 0) r.x = 32'd0;
    else begin
      v = real'(s) / 65536.0;
      b = $realtobits(v);
      r.x = {b[63], 8'(b[62:52] - 11'd896), b[51:29]};
    end
    return r;
  endfunction

  task automatic expect_lit(input string nm, input logic [31:0] x, input bit s, input bit l);
    lit_armed = 1'b1;
    lit_name  = nm;
    lit_res.x = x; lit_res.sat = s; lit_res.len = l;
  endtask

  task automatic step(input bit v, input bit l, input logic [31:0] w, input logic [31:0] a,
                      input logic [31:0] b, input bit ordy, input bit rst);
    bit acc_now;
    bit xfer_now;
    res_t r;
    @(negedge Clk);
    chk("in_ready", 32'(bus.in_ready), exp_busy ? 32'd0 : 32'd1);
    chk("out_valid", 32'(bus.out_valid), 32'(exp_valid));
    if (exp_valid) begin
      chk("x_float", bus.x_float, exp_q[0].x);
      chk("sat", 32'(bus.sat), 32'(exp_q[0].sat));
      chk("len_err", 32'(bus.len_err), 32'(exp_q[0].len));
    end else if (!exp_busy) begin
      chk("x_float_idle", bus.x_float, 32'd0);
      chk("flags_idle", {30'd0, bus.sat, bus.len_err}, 32'd0);
    end
    Reset = rst; bus.in_valid = v; bus.in_last = l;
    bus.weight = w; bus.act = a; bus.bias = b; bus.out_ready = ordy;
    last_acc = 1'b0;
    if (rst) begin
      exp_q.delete(); exp_busy = 1'b0; exp_valid = 1'b0; cd = 0; m_cnt = 0; m_acc = 0;
    end else begin
      acc_now  = v && !exp_busy;
      xfer_now = exp_valid && ordy;
      if (xfer_now) begin
        void'(exp_q.pop_front());
        exp_valid = 1'b0; exp_busy = 1'b0;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) exp_valid = 1'b1;
      end
      if (acc_now) begin
        if (m_cnt == 0) m_acc = longint'(int'(b));
        m_acc += model_term(w, a);
        m_cnt++;
        if (l || m_cnt == N_IN) begin
          r = model_result(m_acc, !l);
          exp_q.push_back(r);
          if (lit_armed) begin
            chk({lit_name, "_x"}, r.x, lit_res.x);
            chk({lit_name, "_flags"}, {30'd0, r.sat, r.len}, {30'd0, lit_res.sat, lit_res.len});
            lit_armed = 1'b0;
          end
          exp_busy = 1'b1; cd = 2; m_cnt = 0;
        end
      end
      last_acc = acc_now;
    end
  endtask

  task automatic send_beat(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b, input bit l);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, l, w, a, b, 1'b1, 1'b0);
      if (last_acc) return;
    end
    n_checks++; n_fail++;
    $display("FAIL send_timeout: beat not accepted within 40 cycles");
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_busy; i++) step(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("drain_done", 32'(exp_busy), 32'd0);
    chk("lit_produced", 32'(lit_armed), 32'd0);
    lit_armed = 1'b0;
    step(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rw, ra;
    Reset = 1'b1; bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.weight = 32'd0;
    bus.act = 32'd0; bus.bias = 32'd0; bus.out_ready = 1'b0;
    repeat (2) @(posedge Clk);

    expect_lit("basic", 32'h4000_0000, 1'b0, 1'b0);
    send_beat(32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0);
    send_beat(32'h0002_0000, 32'h0000_8000, 32'd0, 1'b1);
    repeat (7) step(1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    drain();

    expect_lit("neg", 32'hC020_0000, 1'b0, 1'b0);
    send_beat(32'hFFFD_8000, 32'h0001_0000, 32'd0, 1'b1);
    drain();
    expect_lit("zero", 32'h0000_0000, 1'b0, 1'b0);
    send_beat(32'h0001_0000, 32'hFFFF_0000, 32'h0001_0000, 1'b1);
    drain();

    expect_lit("sat_pos", 32'h46FF_FFFF, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send_beat(32'h0080_0000, 32'h0080_0000, 32'd0, i == 3);
    drain();
    expect_lit("sat_neg", 32'hC700_0000, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send_beat(32'hFF80_0000, 32'h0080_0000, 32'd0, i == 3);
    drain();

    send_beat(32'h0123_0000, 32'h0004_0000, 32'h0050_0000, 1'b0);
    send_beat(32'h0002_0000, 32'h0007_0000, 32'd0, 1'b0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1);
    expect_lit("after_reset", 32'h3F80_0000, 1'b0, 1'b0);
    send_beat(32'd0, 32'd0, 32'h0001_0000, 1'b1);
    drain();

    expect_lit("len_limit", 32'h4080_0000, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) send_beat(32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0);
    expect_lit("fifth_beat", 32'h3F80_0000, 1'b0, 1'b0);
    send_beat(32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0);
    send_beat(32'd0, 32'd0, 32'd0, 1'b1);
    drain();

`ifdef NEURON_ACCUM_ROUND_EN
    expect_lit("round", 32'h3780_0000, 1'b0, 1'b0);
`else
    expect_lit("round", 32'h0000_0000, 1'b0, 1'b0);
`endif
    send_beat(32'h0000_0001, 32'h0000_8000, 32'd0, 1'b1);
    drain();

    for (int c = 0; c < 3000; c++) begin
      rw = $urandom; ra = $urandom;
      if ($urandom_range(0, 3) != 0) rw = {{12{rw[19]}}, rw[19:0]};
      if ($urandom_range(0, 3) != 0) ra = {{12{ra[19]}}, ra[19:0]};
      step($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, rw, ra, $urandom,
           $urandom_range(0, 3) != 0, $urandom_range(0, 299) == 0);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
